// File: rtl/spi_slave_reg_bridge.sv
// SPI responder bridging a command/data byte stream onto a small register bank.
// All SPI lines are oversampled in the clk domain; supports SPI modes 0..3.
module spi_slave_reg_bridge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        MODE,
  input  logic              sclk,
  input  logic              CS_bar,
  input  logic              MOSI,
  output logic              MISO,
  output logic              miso_oe,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              abort
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;

  logic [CNT_W-1:0]  r_cnt;
  logic [BYTE_W-2:0] r_rx;
  logic [BYTE_W-1:0] r_tx;
  logic              r_is_rd;
  logic              r_load;
  logic [ADDR_W-1:0] r_addr;

  logic              r_miso;
  logic              r_miso_oe;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_abort;

  logic              w_sclk;
  logic              w_cs_n;
  logic              w_mosi;
  logic              w_rise;
  logic              w_fall;
  logic              w_sample;
  logic              w_shift;
  logic              w_last_bit;
  logic              w_shift_in;
  logic [BYTE_W-1:0] w_rx_byte;
  logic              w_cmd_done;
  logic              w_byte_done;
  logic              w_abort;

  // Input synchronizers; CS_bar resets to its inactive level
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS_bar};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_sclk_d    <= w_sclk;
    end
  end

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise = w_sclk & ~r_sclk_d;
  assign w_fall = ~w_sclk & r_sclk_d;

  // Modes 0 and 3 sample on rising edges, modes 1 and 2 on falling edges
  assign w_sample   = (MODE[1] ^ MODE[0]) ? w_fall : w_rise;
  assign w_shift    = (MODE[1] ^ MODE[0]) ? w_rise : w_fall;
  assign w_last_bit = w_sample && (r_cnt == CNT_W'(BYTE_W - 1));
  assign w_shift_in = w_sample && (r_state != IDLE);
  assign w_rx_byte  = {r_rx, w_mosi};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A completing byte wins over a simultaneous CS_bar rise
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_done  = 1'b0;
    w_byte_done = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_cs_n) w_state_nxt = CMD;
      end
      CMD: begin
        w_cmd_done = w_last_bit;
        if (w_last_bit) w_state_nxt = DATA;
        if (w_cs_n) begin
          w_state_nxt = IDLE;
          w_abort     = (r_cnt != '0) && !w_last_bit;
        end
      end
      DATA: begin
        w_byte_done = w_last_bit;
        if (w_cs_n) begin
          w_state_nxt = IDLE;
          w_abort     = (r_cnt != '0) && !w_last_bit;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_rx      <= '0;
      r_tx      <= '0;
      r_is_rd   <= 1'b0;
      r_load    <= 1'b0;
      r_addr    <= '0;
      r_miso    <= 1'b0;
      r_miso_oe <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rd_addr <= '0;
      r_abort   <= 1'b0;
    end else begin
      r_wr_en   <= 1'b0;
      r_load    <= 1'b0;
      r_abort   <= w_abort;
      r_miso_oe <= ~w_cs_n;

      if (w_shift_in) begin
        r_rx  <= w_rx_byte[BYTE_W-2:0];
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_state_nxt == IDLE) r_cnt <= '0;

      if (w_cmd_done) begin
        r_is_rd   <= w_rx_byte[BYTE_W-1];
        r_addr    <= w_rx_byte[ADDR_W-1:0];
        r_rd_addr <= w_rx_byte[ADDR_W-1:0];
        r_load    <= w_rx_byte[BYTE_W-1];
      end

      if (w_byte_done) begin
        if (!r_is_rd) begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_addr;
          r_wr_data <= w_rx_byte;
        end
        r_addr    <= r_addr + ADDR_W'(1);
        r_rd_addr <= r_addr + ADDR_W'(1);
        r_load    <= r_is_rd;
      end

      // MISO only moves in read frames while in DATA; the load lands before the next shift edge
      if (r_state == DATA && w_state_nxt == DATA && r_is_rd) begin
        if (w_shift) begin
          r_miso <= r_tx[BYTE_W-1];
          r_tx   <= {r_tx[BYTE_W-2:0], 1'b0};
        end
      end else begin
        r_miso <= 1'b0;
      end
      if (r_load) r_tx <= rd_data;
    end
  end

  assign MISO    = r_miso;
  assign miso_oe = r_miso_oe;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign rd_addr = r_rd_addr;
  assign abort   = r_abort;

endmodule
